// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing front end: image geometry defaults,
// window packing widths and the line-buffer controller FSM encoding.
package img_proc_pkg;

  localparam int unsigned IMG_WIDTH_DEFAULT = 512;
  localparam int unsigned PIX_W             = 8;
  localparam int unsigned KERNEL_DIM        = 3;
  localparam int unsigned ROW_W             = KERNEL_DIM * PIX_W;
  localparam int unsigned WINDOW_W          = KERNEL_DIM * KERNEL_DIM * PIX_W;

  typedef enum logic [0:0] {
    StIdle,
    StRd
  } lb_state_e;

endpackage

// File: rtl/line_buffer.sv
// One row of pixel storage: single write port plus a registered read of three
// neighbouring pixels {buf[p+2], buf[p+1], buf[p]}.
module line_buffer
  import img_proc_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEFAULT,
  localparam int unsigned PtrW     = $clog2(IMG_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  logic [PtrW-1:0]  i_wr_ptr,
  input  logic [PIX_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [PtrW-1:0]  i_rd_ptr,
  output logic [ROW_W-1:0] o_rd_data
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];
  logic [PtrW-1:0]  rd_ptr_p1;
  logic [PtrW-1:0]  rd_ptr_p2;
  logic [ROW_W-1:0] rd_data_q;

  // Caller guarantees i_rd_ptr <= IMG_WIDTH-3, so p+2 never runs off the row.
  assign rd_ptr_p1 = i_rd_ptr + PtrW'(1);
  assign rd_ptr_p2 = i_rd_ptr + PtrW'(2);

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_data_q <= '0;
    end else if (i_rd_en) begin
      rd_data_q <= {mem[rd_ptr_p2], mem[rd_ptr_p1], mem[i_rd_ptr]};
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Rotating line-buffer controller: buffers raster rows into NUM_LB row stores and
// emits one packed 3x3 window per cycle once three rows are resident.
module line_buffer_ctrl
  import img_proc_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEFAULT,
  parameter int unsigned NUM_LB    = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [PIX_W-1:0]    i_pixel_data,
  input  logic                i_pixel_data_valid,
  output logic                o_ready,
  output logic [WINDOW_W-1:0] o_pixel_data,
  output logic                o_pixel_data_valid,
  output logic                o_intr
);

  localparam int unsigned PtrW = $clog2(IMG_WIDTH);
  localparam int unsigned LbW  = $clog2(NUM_LB);
  localparam int unsigned CntW = $clog2(NUM_LB * IMG_WIDTH + 1);

  localparam logic [CntW-1:0] FullCnt   = CntW'(NUM_LB * IMG_WIDTH);
  localparam logic [CntW-1:0] ThreshCnt = CntW'(KERNEL_DIM * IMG_WIDTH);
  localparam logic [CntW-1:0] RowCnt    = CntW'(IMG_WIDTH);
  localparam logic [PtrW-1:0] LastWrPtr = PtrW'(IMG_WIDTH - 1);
  localparam logic [PtrW-1:0] LastRdPtr = PtrW'(IMG_WIDTH - KERNEL_DIM);

  lb_state_e       state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q;
  logic [LbW-1:0]  wr_lb_q;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LbW-1:0]  rd_lb_q, rd_lb_d;
  logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LbW-1:0]  sel_q;
  logic            valid_q;
  logic            intr_q;
  logic            wr_en;
  logic            rd_en;
  logic            row_release;

  logic [ROW_W-1:0] rd_data [NUM_LB];
  logic [LbW-1:0]   sel_mid;
  logic [LbW-1:0]   sel_bot;

  assign o_ready = (pix_cnt_q < FullCnt);
  assign wr_en   = i_pixel_data_valid & o_ready;

  // Write side: fill rows in order, advancing to the next buffer at end of row.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      wr_lb_q  <= '0;
    end else if (wr_en) begin
      if (wr_ptr_q == LastWrPtr) begin
        wr_ptr_q <= '0;
        wr_lb_q  <= wr_lb_q + LbW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    case ({wr_en, row_release})
      2'b10:   pix_cnt_d = pix_cnt_q + CntW'(1);
      2'b01:   pix_cnt_d = pix_cnt_q - RowCnt;
      2'b11:   pix_cnt_d = pix_cnt_q + CntW'(1) - RowCnt;
      default: pix_cnt_d = pix_cnt_q;
    endcase
  end

  // Read FSM: one window per cycle across the row, then release the oldest row.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_lb_d     = rd_lb_q;
    rd_en       = 1'b0;
    row_release = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pix_cnt_q >= ThreshCnt) begin
          state_d = StRd;
        end
      end
      StRd: begin
        rd_en = 1'b1;
        if (rd_ptr_q == LastRdPtr) begin
          row_release = 1'b1;
          rd_ptr_d    = '0;
          rd_lb_d     = rd_lb_q + LbW'(1);
          state_d     = StIdle;
        end else begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      rd_ptr_q  <= '0;
      rd_lb_q   <= '0;
      pix_cnt_q <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_lb_q   <= rd_lb_d;
      pix_cnt_q <= pix_cnt_d;
      valid_q   <= rd_en;
      intr_q    <= row_release;
      // Snapshot the top-row buffer with the read so the output mux lines up
      // with the registered buffer data even after rd_lb has advanced.
      if (rd_en) begin
        sel_q <= rd_lb_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_LB; g++) begin : gen_lb
    line_buffer #(
      .IMG_WIDTH (IMG_WIDTH)
    ) u_line_buffer (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_wr_en   (wr_en && (wr_lb_q == LbW'(g))),
      .i_wr_ptr  (wr_ptr_q),
      .i_wr_data (i_pixel_data),
      .i_rd_en   (rd_en),
      .i_rd_ptr  (rd_ptr_q),
      .o_rd_data (rd_data[g])
    );
  end

  assign sel_mid = sel_q + LbW'(1);
  assign sel_bot = sel_q + LbW'(2);

  // Row 0 (oldest) lands in the low bytes; buffer regs hold, so the window holds too.
  assign o_pixel_data       = {rd_data[sel_bot], rd_data[sel_mid], rd_data[sel_q]};
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl at IMG_WIDTH=8 with pixel value = row*16+col.
module tb_line_buffer_ctrl;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  din = '0;
  logic        din_v = 1'b0;
  logic        ready;
  logic [71:0] dout;
  logic        dout_v;
  logic        intr;

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .IMG_WIDTH (W),
    .NUM_LB    (4)
  ) dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_pixel_data       (din),
    .i_pixel_data_valid (din_v),
    .o_ready            (ready),
    .o_pixel_data       (dout),
    .o_pixel_data_valid (dout_v),
    .o_intr             (intr)
  );

  typedef struct {
    int          top;
    int          col;
    logic [71:0] exp;
  } vec_t;

  vec_t        t1[6];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [71:0] got[$];
  int          pix_at_intr[$];
  int          intr_cnt = 0;
  int          accepted = 0;
  int          acc_at_first = -1;
  logic        intr_prev = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [71:0] win(input int top, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[(rr*3+cc)*8 +: 8] = pix(top + rr, c + cc);
    return w;
  endfunction

  function automatic logic [71:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  always @(negedge clk) begin
    if (dout_v) begin
      if (got.size() == 0) acc_at_first = accepted;
      got.push_back(dout);
    end
    if (intr) begin
      intr_cnt++;
      pix_at_intr.push_back(int'(dut.pix_cnt_q));
      check("intr_single_cycle", {71'b0, intr_prev}, 72'd0);
    end
    intr_prev = intr;
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn  = 1'b0;
    din_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_data", dout, 72'd0);
    check("rst_valid", {71'b0, dout_v}, 72'd0);
    check("rst_intr", {71'b0, intr}, 72'd0);
    check("rst_ready", {71'b0, ready}, 72'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    got.delete();
    pix_at_intr.delete();
    intr_cnt     = 0;
    accepted     = 0;
    acc_at_first = -1;
  endtask

  task automatic write_pix(input int r, input int c, input bit gap);
    logic rdy;
    bit   done;
    done  = 1'b0;
    din   = pix(r, c);
    din_v = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted++;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL write_accept: pixel r%0d c%0d never accepted", r, c);
    end
    din_v = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_rows(input int first, input int last, input bit gap);
    for (int r = first; r <= last; r++)
      for (int c = 0; c < W; c++)
        write_pix(r, c, gap);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_test1(input string tag);
    check({tag, "_count"}, 72'(got.size()), 72'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_win%0d", tag, i), got_at(i), t1[i].exp);
    check({tag, "_intr_cnt"}, 72'(intr_cnt), 72'd1);
  endtask

  initial begin
    t1[0] = '{0, 0, 72'h22_21_20_12_11_10_02_01_00};
    t1[1] = '{0, 1, 72'h23_22_21_13_12_11_03_02_01};
    t1[2] = '{0, 2, 72'h24_23_22_14_13_12_04_03_02};
    t1[3] = '{0, 3, 72'h25_24_23_15_14_13_05_04_03};
    t1[4] = '{0, 4, 72'h26_25_24_16_15_14_06_05_04};
    t1[5] = '{0, 5, 72'h27_26_25_17_16_15_07_06_05};

    // Test 1: three rows back-to-back.
    do_reset();
    write_rows(0, 2, 1'b0);
    drain(30);
    check_test1("t1");

    // Test 2: six rows, four output rows including rd_lb wrap.
    do_reset();
    write_rows(0, 5, 1'b0);
    drain(40);
    check("t2_count", 72'(got.size()), 72'd24);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 6; c++)
        check($sformatf("t2_row%0d_col%0d", k, c), got_at(k*6 + c), win(k, c));
    check("t2_row3_first", got_at(18), 72'h52_51_50_42_41_40_32_31_30);
    check("t2_intr_cnt", 72'(intr_cnt), 72'd4);

    // Test 3: valid toggling every other cycle.
    do_reset();
    write_rows(0, 2, 1'b1);
    drain(30);
    check_test1("t3");
    check("t3_first_after_24", {71'b0, acc_at_first >= 24}, 72'd1);

    // Test 4: row 3 pixel 6 is accepted on the release cycle of the first output row.
    do_reset();
    write_rows(0, 3, 1'b0);
    drain(40);
    check("t4_count", 72'(got.size()), 72'd12);
    check("t4_row1_first", got_at(6), 72'h32_31_30_22_21_20_12_11_10);
    for (int c = 0; c < 6; c++)
      check($sformatf("t4_row1_col%0d", c), got_at(6 + c), win(1, c));
    check("t4_intr_cnt", 72'(intr_cnt), 72'd2);
    check("t4_pix_cnt_release", 72'(pix_at_intr.size() > 0 ? pix_at_intr[0] : -1), 72'd23);

    // Test 5: reset in the middle of an output row, then replay test 1.
    do_reset();
    write_rows(0, 2, 1'b0);
    for (int i = 0; i < 100 && got.size() < 3; i++) @(negedge clk);
    check("t5_reached_3_windows", {71'b0, got.size() >= 3}, 72'd1);
    do_reset();
    write_rows(0, 2, 1'b0);
    drain(30);
    check_test1("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
